// File: rtl/uart_lcd_pkg.sv
// rtl/uart_lcd_pkg.sv - shared constants, state encoding and helpers for the UART-to-LCD pixel path.
package uart_lcd_pkg;

  localparam logic [7:0] SYNC0 = 8'h55;
  localparam logic [7:0] SYNC1 = 8'hAA;

  typedef enum logic [2:0] {
    S_HUNT0,
    S_HUNT1,
    S_HI,
    S_LO,
    S_OUT
  } state_e;

  function automatic int unsigned frame_pixels(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/uart_pixel_packer_idle_timer.sv
// rtl/uart_pixel_packer_idle_timer.sv - idle cycle counter with clear, enable and terminal-count expire.
module idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [23:0] LIMIT = 24'(TIMEOUT_CYC - 1);

  logic [23:0] cnt_q;
  logic [23:0] cnt_d;

  // expire deliberately ignores clr: the owner decides whether a same-cycle byte wins
  assign expire = en && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = expire ? '0 : cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_pixel_packer.sv
// rtl/uart_pixel_packer.sv - hunts a 55 AA header in a byte stream and packs byte pairs into addressed RGB565 pixels.
module uart_pixel_packer
  import uart_lcd_pkg::*;
#(
  parameter int unsigned CLK_FRE     = 50,
  parameter int unsigned H_ACTIVE    = 480,
  parameter int unsigned V_ACTIVE    = 272,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_valid,
  output logic              rx_data_ready,
  output logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(frame_pixels(H_ACTIVE, V_ACTIVE) - 1);

  if (CLK_FRE == 0) begin : g_bad_clk
    $error("uart_pixel_packer: CLK_FRE must be non-zero");
  end
  if ((64'd1 << ADDR_W) < 64'(frame_pixels(H_ACTIVE, V_ACTIVE))) begin : g_bad_addr
    $error("uart_pixel_packer: ADDR_W too small for H_ACTIVE*V_ACTIVE");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << 24)) begin : g_bad_timeout
    $error("uart_pixel_packer: TIMEOUT_CYC out of range");
  end

  state_e            state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic [15:0]       pix_data_q, pix_data_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              pix_valid_q, pix_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        hi_q, hi_d;

  logic byte_acc;
  logic timer_en;
  logic timer_clr;
  logic timer_expire;

  assign byte_acc  = rx_data_valid && rx_ready_q;
  assign timer_en  = (state_q == S_HI) || (state_q == S_LO);
  assign timer_clr = byte_acc || ((state_d == S_HI) && (state_q != S_HI));

  idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .expire(timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    pix_data_d   = pix_data_q;
    pix_addr_d   = pix_addr_q;
    pix_valid_d  = pix_valid_q;
    hi_d         = hi_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      S_HUNT0: begin
        if (byte_acc && rx_data == SYNC0) begin
          state_d = S_HUNT1;
        end
      end
      S_HUNT1: begin
        if (byte_acc) begin
          if (rx_data == SYNC1) begin
            state_d    = S_HI;
            pix_addr_d = '0;
          end else if (rx_data != SYNC0) begin
            state_d = S_HUNT0;
          end
        end
      end
      S_HI: begin
        if (byte_acc) begin
          hi_d    = rx_data;
          state_d = S_LO;
        end else if (timer_expire) begin
          frame_err_d = 1'b1;
          pix_addr_d  = '0;
          hi_d        = '0;
          state_d     = S_HUNT0;
        end
      end
      S_LO: begin
        if (byte_acc) begin
          pix_data_d  = {hi_q, rx_data};
          pix_valid_d = 1'b1;
          state_d     = S_OUT;
        end else if (timer_expire) begin
          frame_err_d = 1'b1;
          pix_addr_d  = '0;
          hi_d        = '0;
          state_d     = S_HUNT0;
        end
      end
      S_OUT: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          if (pix_addr_q == LAST_ADDR) begin
            frame_done_d = 1'b1;
            pix_addr_d   = '0;
            state_d      = S_HUNT0;
          end else begin
            pix_addr_d = pix_addr_q + 1'b1;
            state_d    = S_HI;
          end
        end
      end
      default: state_d = S_HUNT0;
    endcase

    // Ready follows the next state so it drops in the cycle the low byte lands
    rx_ready_d = (state_d != S_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HUNT0;
      rx_ready_q   <= 1'b0;
      pix_data_q   <= '0;
      pix_addr_q   <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      hi_q         <= '0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      pix_data_q   <= pix_data_d;
      pix_addr_q   <= pix_addr_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      hi_q         <= hi_d;
    end
  end

  assign rx_data_ready = rx_ready_q;
  assign pix_data      = pix_data_q;
  assign pix_addr      = pix_addr_q;
  assign pix_valid     = pix_valid_q;
  assign frame_done    = frame_done_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// tb/tb_uart_pixel_packer.sv - self-checking bench for uart_pixel_packer against a byte-stream reference model.
module tb_uart_pixel_packer;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int AW   = 17;
  localparam int TO   = 20;
  localparam int NPIX = H * V;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_data_valid = 1'b0;
  logic          rx_data_ready;
  logic [15:0]   pix_data;
  logic [AW-1:0] pix_addr;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic          frame_done;
  logic          frame_err;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int err_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_addr = 0;
  bit rand_on = 0;

  logic [15:0] obs_data[$];
  int          obs_addr[$];
  logic [15:0] exp_data[$];
  int          exp_addr[$];

  uart_pixel_packer #(
    .CLK_FRE(50), .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .pix_data(pix_data), .pix_addr(pix_addr),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid && pix_ready) begin
        obs_data.push_back(pix_data);
        obs_addr.push_back(int'(pix_addr));
        last_addr = int'(pix_addr);
      end
      if (frame_done) begin
        done_cnt++;
        check("done_last_addr", 32'(last_addr), 32'(NPIX - 1));
      end
      if (frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (frame_done || frame_err) check("done_err_exclusive", 32'(frame_done && frame_err), 32'd0);
    end
  end

  // Reference: each first "55 AA" starts a frame; the following byte pairs are pixels 0..NPIX-1
  task automatic build_expected(input bq_t b);
    int i;
    int p;
    i = 0;
    while (i + 1 < b.size()) begin
      if (b[i] == 8'h55 && b[i+1] == 8'hAA) begin
        i += 2;
        p = 0;
        while (p < NPIX && i + 1 < b.size()) begin
          exp_data.push_back({b[i], b[i+1]});
          exp_addr.push_back(p);
          p++;
          i += 2;
        end
      end else begin
        i++;
      end
    end
  endtask

  task automatic clear_all();
    obs_data.delete(); obs_addr.delete(); exp_data.delete(); exp_addr.delete();
    done_cnt = 0; err_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    bit acc;
    rx_data = b;
    rx_data_valid = 1'b1;
    t = 0;
    acc = 0;
    while (!acc && t < 1000) begin
      @(negedge clk);
      acc = rx_data_ready;
      @(posedge clk);
      #1;
      t++;
    end
    rx_data_valid = 1'b0;
    acc_cyc = cyc;
    if (!acc) check("byte_accept_bound", 32'd0, 32'd1);
  endtask

  task automatic send_stream(input bq_t b, input int max_gap);
    int g;
    foreach (b[i]) begin
      send_byte(b[i]);
      g = $urandom_range(0, max_gap);
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    pix_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
  endtask

  task automatic compare_pixels(input string tag);
    int n;
    check({tag, "_count"}, 32'(obs_data.size()), 32'(exp_data.size()));
    n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, 32'(obs_data[i]), 32'(exp_data[i]));
      check({tag, "_addr"}, 32'(obs_addr[i]), 32'(exp_addr[i]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(rx_data_ready), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    check({tag, "_pix_addr"}, 32'(pix_addr), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    bq_t b;
    int t;
    logic [7:0] x;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Clean frame
    clear_all();
    b = '{8'h55, 8'hAA};
    for (int i = 0; i < 16; i++) b.push_back(8'(i));
    send_stream(b, 0);
    drain();
    build_expected(b);
    compare_pixels("clean");
    if (obs_data.size() > 0) check("clean_first", 32'(obs_data[0]), 32'h0001);
    check("clean_done_cnt", 32'(done_cnt), 32'd1);
    check("clean_err_cnt", 32'(err_cnt), 32'd0);
    check("clean_back_to_hunt", 32'({pix_valid, rx_data_ready}), 32'b01);

    // Header hunt with junk and repeated sync byte
    clear_all();
    b = '{8'h12, 8'h55, 8'h55, 8'hAA, 8'hF8, 8'h00};
    for (int i = 0; i < 14; i++) b.push_back(8'($urandom));
    send_stream(b, 2);
    drain();
    build_expected(b);
    compare_pixels("hunt");
    if (obs_data.size() > 0) check("hunt_first", 32'(obs_data[0]), 32'hF800);
    check("hunt_done_cnt", 32'(done_cnt), 32'd1);

    // Backpressure longer than the timeout
    clear_all();
    pix_ready = 1'b0;
    b = '{8'h55, 8'hAA, 8'h12, 8'h34};
    send_stream(b, 0);
    t = 0;
    while (!pix_valid && t < 20) begin @(negedge clk); t++; end
    check("bp_valid_seen", 32'(pix_valid), 32'd1);
    repeat (50) begin
      @(negedge clk);
      check("bp_valid", 32'(pix_valid), 32'd1);
      check("bp_data", 32'(pix_data), 32'h1234);
      check("bp_addr", 32'(pix_addr), 32'd0);
      check("bp_ready", 32'(rx_data_ready), 32'd0);
      check("bp_err", 32'(frame_err), 32'd0);
    end
    @(posedge clk); #1;
    pix_ready = 1'b1;
    for (int i = 0; i < 14; i++) b.push_back(8'($urandom));
    begin
      bq_t rest;
      for (int i = 4; i < b.size(); i++) rest.push_back(b[i]);
      send_stream(rest, 1);
    end
    drain();
    build_expected(b);
    compare_pixels("bp");
    check("bp_err_cnt", 32'(err_cnt), 32'd0);
    check("bp_done_cnt", 32'(done_cnt), 32'd1);

    // Mid-frame timeout, then a fresh frame must not reuse the stale hi byte
    clear_all();
    b = '{8'h55, 8'hAA, 8'h5A, 8'hC3, 8'h77};
    send_stream(b, 0);
    t = 0;
    while (err_cnt == 0 && t < 100) begin @(posedge clk); #1; t++; end
    check("to_err_cnt", 32'(err_cnt), 32'd1);
    check("to_latency", 32'(err_cyc - acc_cyc), 32'(TO));
    check("to_addr_cleared", 32'(pix_addr), 32'd0);
    build_expected(b);
    compare_pixels("to_partial");
    clear_all();
    b = '{8'h55, 8'hAA, 8'h9A, 8'hBC};
    for (int i = 0; i < 14; i++) b.push_back(8'($urandom));
    send_stream(b, 3);
    drain();
    build_expected(b);
    compare_pixels("to_restart");
    if (obs_data.size() > 0) check("to_restart_first", 32'(obs_data[0]), 32'h9ABC);
    check("to_restart_done", 32'(done_cnt), 32'd1);

    // Reset in the middle of a frame
    clear_all();
    b = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send_stream(b, 0);
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check("midrst_pixels", 32'(obs_data.size()), 32'd3);
    check("midrst_no_pulse", 32'(done_cnt + err_cnt), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    clear_all();
    b.delete();
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom);
      if (x == 8'h55) x = 8'h54;
      b.push_back(x);
    end
    send_stream(b, 1);
    drain();
    build_expected(b);
    compare_pixels("post_rst");
    check("post_rst_done", 32'(done_cnt), 32'd0);

    // Sync bytes inside the payload are plain data
    clear_all();
    b = '{8'h55, 8'hAA, 8'h55, 8'hAA};
    for (int i = 0; i < 14; i++) b.push_back(8'($urandom));
    send_stream(b, 1);
    drain();
    build_expected(b);
    compare_pixels("sync_data");
    if (obs_data.size() > 0) check("sync_data_first", 32'(obs_data[0]), 32'h55AA);
    check("sync_data_done", 32'(done_cnt), 32'd1);

    // Randomized streams with junk prefixes, gaps and random backpressure
    for (int it = 0; it < 4; it++) begin
      clear_all();
      b.delete();
      for (int f = 0; f < 2; f++) begin
        repeat ($urandom_range(0, 5)) begin
          x = ($urandom_range(0, 2) == 0) ? 8'h55 : 8'($urandom);
          if (x == 8'hAA) x = 8'h00;
          b.push_back(x);
        end
        b.push_back(8'h55);
        b.push_back(8'hAA);
        for (int i = 0; i < 2 * NPIX; i++) b.push_back(8'($urandom));
      end
      rand_on = 1;
      fork
        begin
          send_stream(b, 4);
          rand_on = 0;
        end
        begin
          while (rand_on) begin
            @(posedge clk); #1;
            pix_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join
      drain();
      build_expected(b);
      compare_pixels("rand");
      check("rand_done_cnt", 32'(done_cnt), 32'd2);
      check("rand_err_cnt", 32'(err_cnt), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
